// File: rtl/apb_reg_slave_pkg.sv
// Shared types and constants for the APB register slave.
// Word addressing and the counter slot index live here.
package apb_slave_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    localparam int WORD_LSB = 2;
    localparam int WCNT_W   = 4;

    // The counter sits in the first slot past the RW bank.
    function automatic int xfer_cnt_idx(input int num_regs);
        return num_regs;
    endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// Peripheral bus signals between the CPU-side master and the slave.
// Clock and reset are kept as plain ports on the modules.
interface apb_reg_slave_if #(
    parameter int ADDR_W = 8
) ();

    logic              SEL;
    logic              ENABLE;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDR;
    logic [31:0]       WDATA;
    logic [31:0]       RDATA;
    logic              READY;

    modport master (
        output SEL, ENABLE, WRITE, ADDR, WDATA,
        input  RDATA, READY
    );

    modport slave (
        input  SEL, ENABLE, WRITE, ADDR, WDATA,
        output RDATA, READY
    );

endinterface

// File: rtl/apb_reg_slave_wait_counter.sv
// Wait-state down-counter; done marks the last low-READY cycle.
// Holds at zero once drained.
module apb_wait_counter #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RESETn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer: RW register bank, read-only transfer counter,
// programmable wait states and a sticky protocol-error flag.
module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] RESET_VAL   = '0
) (
    input  logic                CLK,
    input  logic                RESETn,
    apb_reg_slave_if.slave      bus,
    output logic [31:0]         REG0_OUT,
    output logic                PROTO_ERR
);

    localparam int   IDX_W        = ADDR_W - WORD_LSB;
    localparam int   RI_W         = $clog2(NUM_REGS);
    localparam int   XFER_CNT_IDX = xfer_cnt_idx(NUM_REGS);
    localparam logic NO_WAIT      = (WAIT_STATES == 0);

    state_e            state, state_n;
    logic [31:0]       regs [NUM_REGS];
    logic [31:0]       xfer_cnt;
    logic [IDX_W-1:0]  idx_q, live_idx, rd_idx;
    logic              wr_q;
    logic [31:0]       wdata_q;
    logic              ready_q, ready_n;
    logic [31:0]       rdata_q, rdata_n, rd_val;
    logic              proto_err;
    logic              setup, latch, dec, complete, err_set;
    logic              wc_done;

    assign live_idx = bus.ADDR[ADDR_W-1:WORD_LSB];
    assign setup    = bus.SEL && !bus.ENABLE;
    // A fresh setup decodes the live address; waits use the latched one.
    assign rd_idx   = setup ? live_idx : idx_q;

    always_comb begin
        rd_val = '0;
        if (int'(rd_idx) < NUM_REGS) begin
            rd_val = regs[rd_idx[RI_W-1:0]];
        end else if (int'(rd_idx) == XFER_CNT_IDX) begin
            rd_val = xfer_cnt;
        end
    end

    apb_wait_counter #(
        .W (WCNT_W)
    ) u_wait (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .load     (latch),
        .load_val (WCNT_W'(WAIT_STATES)),
        .dec      (dec),
        .done     (wc_done)
    );

    always_comb begin
        state_n  = state;
        ready_n  = ready_q;
        rdata_n  = rdata_q;
        latch    = 1'b0;
        dec      = 1'b0;
        complete = 1'b0;
        err_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (setup) begin
                    latch   = 1'b1;
                    state_n = ACCESS;
                    ready_n = NO_WAIT;
                    rdata_n = (NO_WAIT && !bus.WRITE) ? rd_val : '0;
                end else if (bus.SEL && bus.ENABLE) begin
                    err_set = 1'b1;
                end
            end
            ACCESS: begin
                if (!bus.SEL) begin
                    state_n = IDLE;
                    ready_n = 1'b0;
                    rdata_n = '0;
                    err_set = 1'b1;
                end else if (setup) begin
                    latch   = 1'b1;
                    err_set = 1'b1;
                    ready_n = NO_WAIT;
                    rdata_n = (NO_WAIT && !bus.WRITE) ? rd_val : '0;
                end else if (ready_q) begin
                    complete = 1'b1;
                    state_n  = IDLE;
                    ready_n  = 1'b0;
                    rdata_n  = '0;
                end else begin
                    dec = 1'b1;
                    if (wc_done) begin
                        ready_n = 1'b1;
                        rdata_n = wr_q ? '0 : rd_val;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            proto_err <= 1'b0;
            xfer_cnt  <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            state   <= state_n;
            ready_q <= ready_n;
            rdata_q <= rdata_n;
            if (err_set) begin
                proto_err <= 1'b1;
            end
            if (latch) begin
                idx_q   <= live_idx;
                wr_q    <= bus.WRITE;
                wdata_q <= bus.WDATA;
            end
            if (complete) begin
                xfer_cnt <= xfer_cnt + 32'd1;
                if (wr_q && int'(idx_q) < NUM_REGS) begin
                    regs[idx_q[RI_W-1:0]] <= wdata_q;
                end
            end
        end
    end

    assign bus.READY = ready_q;
    assign bus.RDATA = rdata_q;
    assign REG0_OUT  = regs[0];
    assign PROTO_ERR = proto_err;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave at WAIT_STATES 0, 1 and 3.
// A shared stimulus bus is steered to one instance at a time.
module tb_apb_reg_slave;

    logic        clk;
    logic        rstn;
    int          which;
    logic        sel, en, wr;
    logic [7:0]  addr;
    logic [31:0] wdata;

    int checks;
    int failures;

    apb_reg_slave_if #(.ADDR_W(8)) b0 ();
    apb_reg_slave_if #(.ADDR_W(8)) b1 ();
    apb_reg_slave_if #(.ADDR_W(8)) b2 ();

    logic        rdy_a  [3];
    logic [31:0] rdat_a [3];
    logic [31:0] r0_a   [3];
    logic        perr_a [3];

    logic        rdy, perr;
    logic [31:0] rdat, r0;

    assign b0.SEL    = sel && (which == 0);
    assign b1.SEL    = sel && (which == 1);
    assign b2.SEL    = sel && (which == 2);
    assign b0.ENABLE = en;
    assign b1.ENABLE = en;
    assign b2.ENABLE = en;
    assign b0.WRITE  = wr;
    assign b1.WRITE  = wr;
    assign b2.WRITE  = wr;
    assign b0.ADDR   = addr;
    assign b1.ADDR   = addr;
    assign b2.ADDR   = addr;
    assign b0.WDATA  = wdata;
    assign b1.WDATA  = wdata;
    assign b2.WDATA  = wdata;

    assign rdy_a[0]  = b0.READY;
    assign rdy_a[1]  = b1.READY;
    assign rdy_a[2]  = b2.READY;
    assign rdat_a[0] = b0.RDATA;
    assign rdat_a[1] = b1.RDATA;
    assign rdat_a[2] = b2.RDATA;

    assign rdy  = rdy_a[which];
    assign rdat = rdat_a[which];
    assign r0   = r0_a[which];
    assign perr = perr_a[which];

    apb_reg_slave #(
        .NUM_REGS(8), .ADDR_W(8), .WAIT_STATES(0), .RESET_VAL(32'h0)
    ) u_ws0 (
        .CLK(clk), .RESETn(rstn), .bus(b0.slave),
        .REG0_OUT(r0_a[0]), .PROTO_ERR(perr_a[0])
    );

    apb_reg_slave #(
        .NUM_REGS(8), .ADDR_W(8), .WAIT_STATES(1), .RESET_VAL(32'h0)
    ) u_ws1 (
        .CLK(clk), .RESETn(rstn), .bus(b1.slave),
        .REG0_OUT(r0_a[1]), .PROTO_ERR(perr_a[1])
    );

    apb_reg_slave #(
        .NUM_REGS(8), .ADDR_W(8), .WAIT_STATES(3), .RESET_VAL(32'h0)
    ) u_ws3 (
        .CLK(clk), .RESETn(rstn), .bus(b2.slave),
        .REG0_OUT(r0_a[2]), .PROTO_ERR(perr_a[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transfer; checks the access cycle on which READY is seen.
    task automatic xfer(input logic w, input logic [7:0] a,
                        input logic [31:0] d, input int exp_n,
                        input string nm, output logic [31:0] rd,
                        output logic [31:0] r0_pre);
        int n;
        @(negedge clk);
        sel = 1'b1; en = 1'b0; wr = w; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b1;
        n  = 1;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd     = rdat;
        r0_pre = r0;
        checks++;
        if (!rdy || n != exp_n) begin
            failures++;
            $display("FAIL %s ready_cycle got=%0d exp=%0d rdy=%0b",
                     nm, n, exp_n, rdy);
        end
        @(posedge clk);
        #1;
        sel = 1'b0; en = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        which = 0;
        rstn  = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            which = k;
            #1;
            checks++;
            if (rdy !== 1'b0 || rdat !== 32'h0 || perr !== 1'b0 ||
                r0 !== 32'h0) begin
                failures++;
                $display("FAIL reset_state dut=%0d rdy=%0b rdata=%h perr=%0b r0=%h exp=0",
                         k, rdy, rdat, perr, r0);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, pre;
        which = 1;
        xfer(1'b1, 8'h00, 32'hA5A5_0001, 2, "ws1_write", rd, pre);
        checks++;
        if (pre !== 32'h0 || r0 !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL reg0_out_timing before=%h after=%h exp=0/a5a50001",
                     pre, r0);
        end
        xfer(1'b0, 8'h00, 32'h0, 2, "ws1_read", rd, pre);
        checks++;
        if (rd !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL ws1_rdata got=%h exp=a5a50001", rd);
        end
        checks++;
        if (rdat !== 32'h0 || rdy !== 1'b0) begin
            failures++;
            $display("FAIL rdata_clear_after got=%h rdy=%0b exp=0", rdat, rdy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, pre;
        which = 0;
        for (int k = 1; k <= 4; k++) begin
            xfer(1'b1, 8'(k * 4), 32'h0000_1000 + 32'(k), 1,
                 "b2b_write", rd, pre);
        end
        xfer(1'b0, 8'h20, 32'h0, 1, "b2b_cnt_read", rd, pre);
        checks++;
        if (rd !== 32'd4) begin
            failures++;
            $display("FAIL xfer_cnt got=%0d exp=4", rd);
        end
        xfer(1'b0, 8'h10, 32'h0, 1, "b2b_read4", rd, pre);
        checks++;
        if (rd !== 32'h0000_1004) begin
            failures++;
            $display("FAIL reg4_read got=%h exp=00001004", rd);
        end
        xfer(1'b0, 8'h04, 32'h0, 1, "b2b_read1", rd, pre);
        checks++;
        if (rd !== 32'h0000_1001) begin
            failures++;
            $display("FAIL reg1_read got=%h exp=00001001", rd);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, pre;
        which = 1;
        xfer(1'b0, 8'h40, 32'h0, 2, "unmapped_read", rd, pre);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_rdata got=%h exp=0", rd);
        end
        xfer(1'b1, 8'h40, 32'hFFFF_FFFF, 2, "unmapped_write", rd, pre);
        checks++;
        if (r0 !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL unmapped_alias r0=%h exp=a5a50001", r0);
        end
        xfer(1'b0, 8'h1C, 32'h0, 2, "reg7_read", rd, pre);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reg7_read got=%h exp=0", rd);
        end
        xfer(1'b1, 8'h20, 32'h0001_2345, 2, "cnt_write", rd, pre);
        xfer(1'b0, 8'h20, 32'h0, 2, "cnt_read", rd, pre);
        checks++;
        if (rd !== 32'd6) begin
            failures++;
            $display("FAIL cnt_readonly got=%0d exp=6", rd);
        end
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL ws1_no_err perr=%0b exp=0", perr);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, pre;
        which = 2;
        xfer(1'b1, 8'h08, 32'h1234_5678, 4, "ws3_write", rd, pre);
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL pre_abort_err perr=%0b exp=0", perr);
        end
        @(negedge clk);
        sel = 1'b1; en = 1'b0; wr = 1'b1; addr = 8'h08;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        sel = 1'b0; en = 1'b0; wr = 1'b0;
        @(negedge clk);
        checks++;
        if (perr !== 1'b1 || rdy !== 1'b0) begin
            failures++;
            $display("FAIL abort_flags perr=%0b rdy=%0b exp=1/0", perr, rdy);
        end
        xfer(1'b0, 8'h08, 32'h0, 4, "post_abort_read", rd, pre);
        checks++;
        if (rd !== 32'h1234_5678) begin
            failures++;
            $display("FAIL abort_no_commit got=%h exp=12345678", rd);
        end
        xfer(1'b0, 8'h20, 32'h0, 4, "abort_cnt_read", rd, pre);
        checks++;
        if (rd !== 32'd2) begin
            failures++;
            $display("FAIL abort_cnt got=%0d exp=2", rd);
        end
    endtask

    task automatic test_no_setup();
        int seen;
        which = 0;
        seen  = 0;
        @(negedge clk);
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL ws0_pre_err perr=%0b exp=0", perr);
        end
        sel = 1'b1; en = 1'b1; wr = 1'b0; addr = 8'h00;
        repeat (5) begin
            @(negedge clk);
            if (rdy) seen++;
        end
        sel = 1'b0; en = 1'b0;
        checks++;
        if (seen != 0 || perr !== 1'b1) begin
            failures++;
            $display("FAIL no_setup ready_cycles=%0d perr=%0b exp=0/1",
                     seen, perr);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd, pre;
        which = 1;
        @(negedge clk);
        sel = 1'b1; en = 1'b0; wr = 1'b0; addr = 8'h00;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || rdat !== 32'hA5A5_0001) begin
            failures++;
            $display("FAIL pending_read rdy=%0b rdata=%h exp=1/a5a50001",
                     rdy, rdat);
        end
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b0 || rdat !== 32'h0 || r0 !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset rdy=%0b rdata=%h r0=%h exp=0",
                     rdy, rdat, r0);
        end
        rstn = 1'b1;
        sel  = 1'b0; en = 1'b0;
        which = 2;
        #1;
        checks++;
        if (perr !== 1'b0) begin
            failures++;
            $display("FAIL reset_clears_err perr=%0b exp=0", perr);
        end
        which = 1;
        xfer(1'b0, 8'h20, 32'h0, 2, "post_reset_cnt", rd, pre);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_cnt got=%0d exp=0", rd);
        end
        xfer(1'b0, 8'h00, 32'h0, 2, "post_reset_reg0", rd, pre);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_reg0 got=%h exp=0", rd);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_unmapped();
        test_abort();
        test_no_setup();
        test_reset_mid_access();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
